cdc_bus_rx_ctrl: RTL



---
 rtl/cdc_rx_pkg.sv | 31 +++
 rtl/cdc_rx_flag_sync.sv | 28 ++
 rtl/cdc_bus_rx_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cdc_rx_pkg.sv
// Shared definitions for the cdc_bus_rx_ctrl receive-side crossing controller.
// The optional stability check is enabled with CDC_RX_STABILITY_CHECK_EN.
package cdc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        ACK    = 2'd3
    } rx_state_e;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;
    localparam int SETTLE_CYCLES_MIN = 1;
    localparam int SETTLE_CYCLES_MAX = 15;

    localparam int ERR_CNT_W    = 8;
    localparam int SETTLE_CNT_W = $clog2(SETTLE_CYCLES_MAX + 1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        logic [ERR_CNT_W-1:0] res;
        if (cnt == {ERR_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/cdc_rx_flag_sync.sv
// Multi-stage 1-bit level synchronizer with asynchronous active-low reset.
// Chain flops are marked so tools keep them distinct, unshared and out of SRLs.
module cdc_rx_flag_sync
    import cdc_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE", dont_touch = "true", keep = "true", shreg_extract = "no" *)
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_bus_rx_ctrl.sv
// Receive-side 4-phase req/ack bus crossing controller into the clk domain.
// Define CDC_RX_STABILITY_CHECK_EN to require consecutive identical samples before capture.
module cdc_bus_rx_ctrl
    import cdc_rx_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_req,
    input  logic [WIDTH-1:0]     src_data,
    output logic                 dst_ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Out-of-range parameters are clamped into the supported range.
    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
    localparam int SETTLE_N = (SETTLE_CYCLES < SETTLE_CYCLES_MIN) ? SETTLE_CYCLES_MIN :
                              (SETTLE_CYCLES > SETTLE_CYCLES_MAX) ? SETTLE_CYCLES_MAX : SETTLE_CYCLES;
    localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_N - 1);

    logic                    req_s;
    rx_state_e               state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    dst_ack_q, dst_ack_d;
    logic                    busy_q;

    // Source data crosses unsynchronized; timing is false-pathed and it is only consumed once settled.
    (* keep = "true", dont_touch = "true" *)
    logic [WIDTH-1:0]        data_q;

    cdc_rx_flag_sync #(
        .STAGES (SYNC_N)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (src_req),
        .q_o   (req_s)
    );

    // Free-running capture of the source bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= src_data;
        end
    end

`ifdef CDC_RX_STABILITY_CHECK_EN
    logic [WIDTH-1:0]     data_prev_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Previous sample and restart counter for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_prev_q <= {WIDTH{1'b0}};
            err_cnt_q   <= {ERR_CNT_W{1'b0}};
        end else begin
            data_prev_q <= data_q;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = {ERR_CNT_W{1'b0}};
`endif

    // Next-state and output logic of the handshake FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        dst_ack_d   = dst_ack_q;
`ifdef CDC_RX_STABILITY_CHECK_EN
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                // A request withdrawn before capture is a protocol violation: drop it silently.
                if (!req_s) begin
                    state_d = IDLE;
                end else
`ifdef CDC_RX_STABILITY_CHECK_EN
                if (data_q != data_prev_q) begin
                    cnt_d     = CNT_LOAD;
                    err_cnt_d = err_cnt_inc(err_cnt_q);
                end else
`endif
                if (cnt_q == {SETTLE_CNT_W{1'b0}}) begin
                    out_data_d  = data_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - {{(SETTLE_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    dst_ack_d   = 1'b1;
                    state_d     = ACK;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    dst_ack_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    dst_ack_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                dst_ack_d   = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {SETTLE_CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            dst_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dst_ack_q   <= dst_ack_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign dst_ack   = dst_ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
